// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_queue
//  Description : Decoupled instruction fetch. Issues word reads to a
//                synchronous instruction ROM (1-cycle latency), buffers
//                {pc, instruction} pairs in a QDEPTH-entry FIFO and presents
//                the head to decode with a valid/ready handshake. Resolves
//                jr/j/jal/beq/bne redirects for the head being consumed,
//                flushing the queue and any in-flight ROM read.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
   parameter int          ROM_AW   = 14,
   parameter int          QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                        clock,
   input  logic                        reset,
   // instruction ROM
   output logic [ROM_AW-1:0]           imem_addr,
   output logic                        imem_en,
   input  logic [31:0]                 imem_data,
   // decode interface
   output logic [31:0]                 Instruction,
   output logic [31:0]                 inst_pc,
   output logic [31:0]                 PC_plus_4_out,
   output logic                        inst_valid,
   input  logic                        inst_ready,
   // redirect inputs for the head instruction
   input  logic [31:0]                 Add_result,
   input  logic [31:0]                 Read_data_1,
   input  logic                        Branch,
   input  logic                        nBranch,
   input  logic                        Jmp,
   input  logic                        Jal,
   input  logic                        Jrn,
   input  logic                        Zero,
   output logic [31:0]                 opcplus4,
   output logic [$clog2(QDEPTH):0]     q_level
);

   localparam int PTR_W = $clog2(QDEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0]      fetch_pc;     // address of the next ROM read to issue
   logic [31:0]      tag;          // pc of the read currently in flight
   logic             inflight;     // ROM data on imem_data belongs to tag
   logic [PTR_W:0]   wr_ptr;       // extra msb distinguishes full from empty
   logic [PTR_W:0]   rd_ptr;
   logic [31:0]      pc_mem   [QDEPTH];
   logic [31:0]      data_mem [QDEPTH];

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] rd_idx;
   logic [PTR_W+1:0] demand;       // queued entries plus the reserved slot
   logic             has_room;
   logic             accept;
   logic             take;
   logic             redirect;
   logic             push;
   logic [31:0]      target;
   logic             unused_bits;

   assign wr_idx     = wr_ptr[PTR_W-1:0];
   assign rd_idx     = rd_ptr[PTR_W-1:0];
   assign q_level    = wr_ptr - rd_ptr;
   assign inst_valid = (wr_ptr != rd_ptr);

   // An in-flight read already owns a FIFO slot, so it counts toward demand.
   assign demand   = {1'b0, q_level} + {{(PTR_W+1){1'b0}}, inflight};
   assign has_room = (demand < (PTR_W+2)'(QDEPTH));

   // Control flags only matter for the instruction actually being consumed.
   assign accept   = inst_valid & inst_ready;
   assign take     = Jrn | Jmp | Jal | (Branch & Zero) | (nBranch & ~Zero);
   assign redirect = accept & take;

   assign imem_en   = ~reset & ~redirect & has_room;
   assign imem_addr = fetch_pc[ROM_AW+1:2];

   // A redirect kills the response arriving this cycle along with the queue.
   assign push = inflight & ~redirect;

   // Head outputs come straight from FIFO registers, zeroed when empty.
   assign Instruction   = inst_valid ? data_mem[rd_idx] : 32'h0;
   assign inst_pc       = inst_valid ? pc_mem[rd_idx]   : 32'h0;
   assign PC_plus_4_out = inst_pc + 32'd4;

   // Redirect target selection: register jump beats absolute jump beats branch.
   always_comb begin
      target = {Add_result[29:0], 2'b00};
      if (Jrn) begin
         target = {Read_data_1[31:2], 2'b00};
      end else if (Jmp | Jal) begin
         target = {PC_plus_4_out[31:28], Instruction[25:0], 2'b00};
      end
   end

   // Bits that are architecturally discarded by the target formats.
   assign unused_bits = ^{Read_data_1[1:0], Add_result[31:30]};

   // ------------------------------------------------------------------------
   // Fetch PC, in-flight tracking, FIFO pointers and jal link register
   // ------------------------------------------------------------------------
   // Sequential control: reset beats redirect, redirect beats issue/fill/pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         tag      <= 32'h0;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         opcplus4 <= 32'h0;
      end else begin
         if (redirect) begin
            fetch_pc <= target;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            inflight <= imem_en;
            if (imem_en) begin
               tag      <= fetch_pc;
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
               wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (accept) begin
               rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
         end
         if (accept && Jal) begin
            opcplus4 <= PC_plus_4_out;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage (no reset needed: validity is carried by the pointers)
   // ------------------------------------------------------------------------
   // Capture the returning ROM word with its pc at the tail slot.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         pc_mem[wr_idx]   <= tag;
         data_mem[wr_idx] <= imem_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_queue
//  Description : Directed, table-driven bench for ifetch_queue with a
//                synchronous ROM model and hand-written wrap sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

   localparam int ROM_AW = 14;
   localparam int QDEPTH = 4;

   localparam logic [4:0] BR = 5'd1;
   localparam logic [4:0] NB = 5'd2;
   localparam logic [4:0] JM = 5'd4;
   localparam logic [4:0] JL = 5'd8;
   localparam logic [4:0] JR = 5'd16;
   localparam logic [31:0] LNK = 32'h3000_0024;

   logic              clock = 1'b0;
   logic              reset;
   logic [ROM_AW-1:0] imem_addr;
   logic              imem_en;
   logic [31:0]       imem_data = 32'h0;
   logic [31:0]       Instruction;
   logic [31:0]       inst_pc;
   logic [31:0]       PC_plus_4_out;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       Add_result;
   logic [31:0]       Read_data_1;
   logic              Branch, nBranch, Jmp, Jal, Jrn, Zero;
   logic [31:0]       opcplus4;
   logic [2:0]        q_level;

   int checks   = 0;
   int failures = 0;

   ifetch_queue #(.ROM_AW(ROM_AW), .QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
      .Instruction(Instruction), .inst_pc(inst_pc), .PC_plus_4_out(PC_plus_4_out),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .Add_result(Add_result), .Read_data_1(Read_data_1),
      .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn), .Zero(Zero),
      .opcplus4(opcplus4), .q_level(q_level)
   );

   always #5 clock = ~clock;

   // ROM contents: word i holds i+0x100, except word 8 which holds a jal
   // with a 26-bit index of 0x40 (only consumed at pc 0x3000_0020).
   function automatic logic [31:0] rom_word(input logic [ROM_AW-1:0] a);
      if (a == ROM_AW'(8)) return 32'h0C00_0040;
      return 32'(a) + 32'h100;
   endfunction

   // Synchronous ROM, one-cycle read latency.
   always @(posedge clock) begin
      if (imem_en) imem_data <= rom_word(imem_addr);
   end

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [4:0]  ctl;
      logic        zero;
      logic [31:0] add;
      logic [31:0] rd1;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einst;
      int          elvl;
      logic        een;
      logic [31:0] eaddr;
      logic [31:0] eopc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic rdy, input logic [4:0] ctl,
                               input logic zero, input logic [31:0] add, input logic [31:0] rd1,
                               input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                               input int elvl, input logic een, input logic [31:0] eaddr,
                               input logic [31:0] eopc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.ctl = ctl; v.zero = zero; v.add = add; v.rd1 = rd1;
      v.ev = ev; v.epc = epc; v.einst = einst; v.elvl = elvl; v.een = een;
      v.eaddr = eaddr; v.eopc = eopc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      reset       = v.rst;
      inst_ready  = v.rdy;
      Branch      = v.ctl[0];
      nBranch     = v.ctl[1];
      Jmp         = v.ctl[2];
      Jal         = v.ctl[3];
      Jrn         = v.ctl[4];
      Zero        = v.zero;
      Add_result  = v.add;
      Read_data_1 = v.rd1;
   endtask

   initial begin
      bit found;
      int lat;

      // cycle-by-cycle expectations, one row per clock cycle
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 1,32'h0,32'h100,1,1,32'h2,0));
      tbl.push_back(mk(0,1,0,0,0,0, 1,32'h4,32'h101,1,1,32'h3,0));
      // backpressure for ten cycles
      tbl.push_back(mk(0,0,0,0,0,0, 1,32'h8,32'h102,1,1,32'h4,0));
      tbl.push_back(mk(0,0,0,0,0,0, 1,32'h8,32'h102,2,1,32'h5,0));
      tbl.push_back(mk(0,0,0,0,0,0, 1,32'h8,32'h102,3,0,32'h6,0));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(0,0,0,0,0,0, 1,32'h8,32'h102,4,0,32'h6,0));
      // release: drain in order
      tbl.push_back(mk(0,1,0,0,0,0, 1,32'h8,32'h102,4,0,32'h6,0));
      tbl.push_back(mk(0,1,0,0,0,0, 1,32'hC,32'h103,3,1,32'h6,0));
      // beq taken at pc 0x10 -> 0x100
      tbl.push_back(mk(0,1,BR,1,32'h40,0, 1,32'h10,32'h104,2,0,32'h7,0));
      tbl.push_back(mk(0,1,JM,0,0,0, 0,32'h0,32'h0,0,1,32'h40,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h41,0));
      // jr + branch both set: jr wins, low bits cleared -> 0x200
      tbl.push_back(mk(0,1,JR|BR,1,32'h50,32'h203, 1,32'h100,32'h140,1,0,32'h42,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h80,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h81,0));
      // jr to 0x3000_0020 to set up the jal
      tbl.push_back(mk(0,1,JR,0,0,32'h3000_0020, 1,32'h200,32'h180,1,0,32'h82,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h8,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h9,0));
      // jal at 0x3000_0020 -> 0x3000_0100, link 0x3000_0024
      tbl.push_back(mk(0,1,JL,0,0,0, 1,32'h3000_0020,32'h0C00_0040,1,0,32'hA,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h40,LNK));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h41,LNK));
      // bne taken to 0x10; link must hold
      tbl.push_back(mk(0,1,NB,0,32'h4,0, 1,32'h3000_0100,32'h140,1,0,32'h42,LNK));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h4,LNK));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h5,LNK));
      // beq not taken, then jmp ignored while ready=0
      tbl.push_back(mk(0,1,BR,0,32'h80,0, 1,32'h10,32'h104,1,1,32'h6,LNK));
      tbl.push_back(mk(0,0,JM,0,0,0, 1,32'h14,32'h105,1,1,32'h7,LNK));
      tbl.push_back(mk(0,1,0,0,0,0, 1,32'h14,32'h105,2,1,32'h8,LNK));
      tbl.push_back(mk(0,0,0,0,0,0, 1,32'h18,32'h106,2,1,32'h9,LNK));
      // reset with three queued and one read in flight
      tbl.push_back(mk(1,0,0,0,0,0, 1,32'h18,32'h106,3,0,32'hA,LNK));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 0,32'h0,32'h0,0,1,32'h1,0));
      tbl.push_back(mk(0,1,0,0,0,0, 1,32'h0,32'h100,1,1,32'h2,0));

      // reset state
      apply(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0));
      repeat (2) @(posedge clock);
      #1;
      #4;
      chk("rst_en",    32'(imem_en),    32'h0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_level", 32'(q_level),    32'h0);
      chk("rst_addr",  32'(imem_addr),  32'h0);
      chk("rst_opc",   opcplus4,        32'h0);
      @(posedge clock);
      #1;

      foreach (tbl[i]) begin
         apply(tbl[i]);
         #4;
         chk($sformatf("c%0d_valid", i), 32'(inst_valid),   32'(tbl[i].ev));
         chk($sformatf("c%0d_pc", i),    inst_pc,            tbl[i].epc);
         chk($sformatf("c%0d_inst", i),  Instruction,        tbl[i].einst);
         chk($sformatf("c%0d_pc4", i),   PC_plus_4_out,      tbl[i].epc + 32'd4);
         chk($sformatf("c%0d_level", i), 32'(q_level),       32'(tbl[i].elvl));
         chk($sformatf("c%0d_en", i),    32'(imem_en),       32'(tbl[i].een));
         chk($sformatf("c%0d_addr", i),  32'(imem_addr),     tbl[i].eaddr);
         chk($sformatf("c%0d_opc", i),   opcplus4,           tbl[i].eopc);
         @(posedge clock);
         #1;
      end

      // fetch_pc wrap: jr to 0xFFFFFFFC, then the next word is pc 0
      chk("wrap_pre_valid", 32'(inst_valid), 32'h1);
      apply(mk(0,1,JR,0,0,32'hFFFF_FFFF, 0,0,0,0,0,0,0));
      @(posedge clock);
      #1;
      apply(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0));
      found = 1'b0;
      lat   = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (inst_valid) begin
            found = 1'b1;
            lat   = k;
            break;
         end
      end
      if (!found) begin
         checks++;
         failures++;
         $display("FAIL wrap_timeout: inst_valid never rose within 8 cycles, expected after 2");
      end else begin
         chk("wrap_latency", 32'(lat),       32'd2);
         chk("wrap_pc",      inst_pc,        32'hFFFF_FFFC);
         chk("wrap_inst",    Instruction,    32'h0000_40FF);
         chk("wrap_pc4",     PC_plus_4_out,  32'h0);
         @(negedge clock);
         chk("wrap_next_valid", 32'(inst_valid), 32'h1);
         chk("wrap_next_pc",    inst_pc,         32'h0);
         chk("wrap_next_inst",  Instruction,     32'h100);
         chk("wrap_opc",        opcplus4,        32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
